// File: rtl/traffic_ctrl_nphase.sv
// N-phase traffic signal controller: green/yellow/all-red cycling plus flashing-yellow mode.
// Define TRAFFIC_DEMAND_SKIP_EN to enable demand-driven phase skipping and green hold.
module traffic_ctrl_nphase #(
    parameter int unsigned N_PHASES          = 2,
    parameter int unsigned GREEN_CYCLES      = 30,
    parameter int unsigned YELLOW_CYCLES     = 5,
    parameter int unsigned RED_RED_CYCLES    = 2,
    parameter int unsigned FLASH_HALF_CYCLES = 8000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode_switch,
    input  logic [N_PHASES-1:0] det,
    output logic [N_PHASES-1:0] red,
    output logic [N_PHASES-1:0] yellow,
    output logic [N_PHASES-1:0] green,
    output logic [2:0]          phase,
    output logic                flashing
);

    localparam int unsigned MAX_A = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
    localparam int unsigned MAX_B = (RED_RED_CYCLES > FLASH_HALF_CYCLES) ?
                                    RED_RED_CYCLES : FLASH_HALF_CYCLES;
    localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TW    = $clog2(MAX_D + 1);

    localparam logic [TW-1:0] T_GREEN  = TW'(GREEN_CYCLES);
    localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_CYCLES);
    localparam logic [TW-1:0] T_RR     = TW'(RED_RED_CYCLES);
    localparam logic [TW-1:0] T_FLASH  = TW'(FLASH_HALF_CYCLES);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [2:0]    P_LAST   = 3'(N_PHASES - 1);

    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [2:0]            p_q, p_d;
    logic [N_PHASES-1:0]   demand_q, demand_d;
    logic                  flash_on_q, flash_on_d;

    logic [N_PHASES-1:0]   p_oh;
    logic [2:0]            p_next;

    always_comb begin
        for (int i = 0; i < int'(N_PHASES); i++) begin
            p_oh[i] = (p_q == 3'(i));
        end
    end

`ifdef TRAFFIC_DEMAND_SKIP_EN
    logic [2*N_PHASES-1:0] dem_dbl;
    logic [N_PHASES-1:0]   dem_rot;
    logic [3:0]            cand;
    logic                  found;
    logic                  other_dem;

    // dem_rot[k] is the demand of phase (p+1+k) mod N; lowest k wins.
    always_comb begin
        dem_dbl   = {demand_q, demand_q} >> (4'(p_q) + 4'd1);
        dem_rot   = dem_dbl[N_PHASES-1:0];
        cand      = 4'd0;
        found     = 1'b0;
        for (int k = int'(N_PHASES) - 1; k >= 0; k--) begin
            if (dem_rot[k]) begin
                cand  = 4'(k);
                found = 1'b1;
            end
        end
        cand = 4'(p_q) + 4'd1 + cand;
        if (cand >= 4'(N_PHASES)) begin
            cand = cand - 4'(N_PHASES);
        end
        p_next    = found ? cand[2:0] : ((p_q == P_LAST) ? 3'd0 : p_q + 3'd1);
        other_dem = |(demand_q & ~p_oh);
    end
`else
    always_comb begin
        p_next = (p_q == P_LAST) ? 3'd0 : p_q + 3'd1;
    end
`endif

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        p_d        = p_q;
        flash_on_d = flash_on_q;
        // Clearing the served phase wins over a simultaneous detector hit.
        demand_d   = (demand_q | det) & ~((state_q == S_GREEN) ? p_oh : '0);

        if (state_q != S_FLASH && !mode_switch) begin
            state_d    = S_FLASH;
            timer_d    = T_FLASH;
            flash_on_d = 1'b1;
        end else begin
            unique case (state_q)
                S_GREEN: begin
                    if (timer_q <= T_ONE) begin
`ifdef TRAFFIC_DEMAND_SKIP_EN
                        if (other_dem) begin
                            state_d = S_YELLOW;
                            timer_d = T_YELLOW;
                        end else begin
                            timer_d = '0;
                        end
`else
                        state_d = S_YELLOW;
                        timer_d = T_YELLOW;
`endif
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
                S_YELLOW: begin
                    if (timer_q <= T_ONE) begin
                        state_d = S_ALLRED;
                        timer_d = T_RR;
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
                S_ALLRED: begin
                    if (timer_q <= T_ONE) begin
                        state_d = S_GREEN;
                        timer_d = T_GREEN;
                        p_d     = p_next;
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
                S_FLASH: begin
                    if (mode_switch) begin
                        state_d    = S_ALLRED;
                        timer_d    = T_RR;
                        p_d        = P_LAST;
                        flash_on_d = 1'b0;
                    end else if (timer_q <= T_ONE) begin
                        timer_d    = T_FLASH;
                        flash_on_d = ~flash_on_q;
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
                default: state_d = S_ALLRED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_ALLRED;
            timer_q    <= T_RR;
            p_q        <= P_LAST;
            demand_q   <= '0;
            flash_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            p_q        <= p_d;
            demand_q   <= demand_d;
            flash_on_q <= flash_on_d;
        end
    end

    always_comb begin
        red      = '0;
        yellow   = '0;
        green    = '0;
        flashing = 1'b0;
        phase    = p_q;
        unique case (state_q)
            S_GREEN: begin
                green = p_oh;
                red   = ~p_oh;
            end
            S_YELLOW: begin
                yellow = p_oh;
                red    = ~p_oh;
            end
            S_ALLRED: red = '1;
            S_FLASH: begin
                yellow   = flash_on_q ? '1 : '0;
                flashing = 1'b1;
            end
            default: red = '1;
        endcase
    end

endmodule

// File: doc/traffic_ctrl_nphase.md
TRAFFIC_CTRL_NPHASE -- requirements
Module: traffic_ctrl_nphase

Interface
REQ-001 SHALL have parameter N_PHASES, default 2: number of conflicting signal phases (legal range 2..8).
REQ-002 SHALL have parameter GREEN_CYCLES, default 30: green duration in clocks (>=1).
REQ-003 SHALL have parameter YELLOW_CYCLES, default 5: yellow duration in clocks (>=1).
REQ-004 SHALL have parameter RED_RED_CYCLES, default 2: all-red clearance duration in clocks (>=1).
REQ-005 SHALL have parameter FLASH_HALF_CYCLES, default 8000000: flash half-period in clocks (>=1).
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port mode_switch, input, 1: 1 = normal cycling, 0 = flashing-yellow mode.
REQ-009 SHALL have port det, input, N_PHASES: per-phase vehicle demand request, level or pulse.
REQ-010 SHALL have ports red, yellow, green, output, N_PHASES each: per-phase lamp drives, bit i = phase i.
REQ-011 SHALL have port phase, output, 3: index of the current or last-served phase.
REQ-012 SHALL have port flashing, output, 1: high while in S_FLASH.

Function
REQ-013 SHALL implement states S_GREEN, S_YELLOW, S_ALLRED and S_FLASH, plus a phase index p and a down-counting timer sized to the largest duration parameter.
REQ-014 SHALL drive outputs as a decode of registered state only (Moore); no input reaches an output combinationally.
REQ-015 In S_GREEN, green[p]=1 and red=1 for every other phase; in S_YELLOW, yellow[p]=1 and red=1 for all others; in S_ALLRED, red is all ones.
REQ-016 SHALL guarantee that at most one phase is non-red in any cycle.
REQ-017 SHALL hold S_GREEN for exactly GREEN_CYCLES clocks, S_YELLOW for YELLOW_CYCLES clocks and S_ALLRED for RED_RED_CYCLES clocks.
REQ-018 Sequence: S_GREEN -> S_YELLOW -> S_ALLRED -> S_GREEN with p advanced; the phase index wraps from N_PHASES-1 to 0.
REQ-019 SHALL keep a sticky demand register: bit i is set by det[i], and is cleared every cycle that phase i is in S_GREEN; the clear wins on a simultaneous set.
REQ-020 mode_switch=0 in any non-flash state SHALL force S_FLASH on the next clock.
REQ-021 In S_FLASH, all yellow bits SHALL be 1 for FLASH_HALF_CYCLES clocks and then 0 for FLASH_HALF_CYCLES clocks, repeating, starting with the on half; red and green are 0.
REQ-022 On mode_switch=1 in S_FLASH, the block SHALL go to S_ALLRED with the timer loaded to RED_RED_CYCLES and p=N_PHASES-1, so the next green is phase 0.
REQ-023 mode_switch SHALL be sampled every cycle; it is not synchronised internally, and the caller supplies a synchronous level.

Reset
REQ-024 On rst=1 the block SHALL enter S_ALLRED immediately and asynchronously, from any state including mid-green, mid-yellow and mid-flash.
REQ-025 Reset values: timer=RED_RED_CYCLES, p=N_PHASES-1, demand=0, red=all ones, yellow=0, green=0, phase=N_PHASES-1, flashing=0.
REQ-026 After rst deasserts, the block SHALL show RED_RED_CYCLES clocks of all-red before green on phase 0, or S_FLASH if mode_switch=0.

Configuration
REQ-027 Macro TRAFFIC_DEMAND_SKIP_EN SHALL select the phase-advance policy.
- Undefined: fixed round-robin per REQ-018; the demand register is still kept but ignored.
REQ-028 With TRAFFIC_DEMAND_SKIP_EN defined, the next phase SHALL be the first phase with demand, searched cyclically from p+1.
- If no demand is pending, next = p+1 (wrap).
REQ-029 With TRAFFIC_DEMAND_SKIP_EN defined, at green expiry with no pending demand on any other phase, the block SHALL hold S_GREEN with timer at 0.
- It enters S_YELLOW on the first clock after some other phase's demand bit is set.

Verification
Parameters for all scenarios: N_PHASES=3, GREEN=30, YELLOW=5, RED_RED=2, FLASH_HALF=5, mode_switch=1, det=0 unless stated.
REQ-030 Release rst -> red=111 for 2 clocks, then green=001 for 30, yellow=001 for 5, red=111 for 2, then green=010.
REQ-031 Run 3 full cycles -> green order 001, 010, 100, 001; phase wraps 2->0; never more than one non-red bit (assertion every cycle).
REQ-032 mode_switch=0 at clock 10 of phase 1 green -> next clock yellow=111 and flashing=1; yellow toggles 111/000 every 5 clocks; mode_switch=1 -> red=111 for 2 clocks, then green=001.
REQ-033 Assert rst asynchronously mid-yellow on phase 2 -> red=111 and phase=2 before the next clk edge; after release, green=001 follows 2 clocks later.
REQ-034 With TRAFFIC_DEMAND_SKIP_EN: one-clock det=100 pulse during phase 0 green -> phase 0 yellow, all-red, then green=100 (phase 1 skipped); with no further det, green=100 is held indefinitely.
REQ-035 With TRAFFIC_DEMAND_SKIP_EN: det=100 held for the whole of phase 2 green -> demand[2] stays 0 while green; after phase 2 leaves green, demand[2] re-sets.
